// File: rtl/score_display_pkg.sv
// Shared types, constants and helpers for the score display path.
// Holds the conversion FSM states, segment patterns and the BCD add-3 step.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    localparam int BCD_W = 12;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 goes dark.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = '0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            else
                res[i*4 +: 4] = bcd[i*4 +: 4];
        end
        return res;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Score input and seven-segment drive bundle between the score source and the display block.
interface score_display_if;
    logic [7:0] score;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    modport master (
        output score,
        input  seg,
        input  an,
        input  dp,
        input  busy
    );

    modport slave (
        input  score,
        output seg,
        output an,
        output dp,
        output busy
    );
endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter: re-converts whenever the input differs
// from the last converted value and publishes the result only when complete.
//
// state | meaning
// IDLE  | waiting; compares bin with shown_bin, starts a conversion on mismatch
// CONV  | one add-3 + shift per cycle, eight cycles
// DONE  | publishes bcd and records the converted value in shown_bin
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             RST_N,
    input  logic [7:0]       bin,
    output logic [BCD_W-1:0] bcd,
    output logic             busy
);

    conv_state_t            state;
    conv_state_t            state_nxt;
    logic [7:0]             shift_bin;
    logic [7:0]             latched;
    logic [7:0]             shown_bin;
    logic [BCD_W-1:0]       acc;
    logic [BCD_W+7:0]       shifted;
    logic [2:0]             cnt;
    logic                   start;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (bin != shown_bin) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (cnt == 3'd7)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hundreds never exceeds 2 for an 8-bit input, so the shifted-out MSB is always 0.
    assign shifted = {bcd_add3(acc), shift_bin} << 1;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            shift_bin <= '0;
            latched   <= '0;
            shown_bin <= '0;
            acc       <= '0;
            cnt       <= '0;
            bcd       <= '0;
        end else begin
            if (start) begin
                shift_bin <= bin;
                latched   <= bin;
                acc       <= '0;
                cnt       <= '0;
            end else if (state == CONV) begin
                {acc, shift_bin} <= shifted;
                cnt              <= cnt + 3'd1;
            end else if (state == DONE) begin
                bcd       <= acc;
                shown_bin <= latched;
            end
        end
    end

endmodule

// File: rtl/score_display.sv
// Score to 4-digit common-anode seven-segment display: BCD conversion,
// digit scanning and leading-zero blanking.
module score_display
    import score_pkg::*;
#(
    parameter int SCAN_DIV      = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic         clk,
    input  logic         RST_N,
    score_display_if.slave bus
);

    localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    logic [PW-1:0]    presc;
    logic [1:0]       idx;
    logic [BCD_W-1:0] disp_reg;
    logic             conv_busy;
    logic [3:0]       digit;
    logic [3:0]       an_sel;
    logic             blank;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .RST_N (RST_N),
        .bin   (bus.score),
        .bcd   (disp_reg),
        .busy  (conv_busy)
    );

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_TC) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Slot 3 has no digit fitted and is always dark.
    always_comb begin
        digit  = 4'd0;
        blank  = 1'b1;
        an_sel = 4'b1111;
        case (idx)
            2'd0: begin
                digit  = disp_reg[3:0];
                blank  = 1'b0;
                an_sel = 4'b1110;
            end
            2'd1: begin
                digit  = disp_reg[7:4];
                blank  = BLANK_LEADING && (disp_reg[11:4] == 8'd0);
                an_sel = 4'b1101;
            end
            2'd2: begin
                digit  = disp_reg[11:8];
                blank  = BLANK_LEADING && (disp_reg[11:8] == 4'd0);
                an_sel = 4'b1011;
            end
            default: begin
                blank = 1'b1;
            end
        endcase
        if (blank)
            an_sel = 4'b1111;
    end

    assign bus.seg  = blank ? SEG_BLANK : seg7_decode(digit);
    assign bus.an   = an_sel;
    assign bus.dp   = 1'b1;
    assign bus.busy = conv_busy;

endmodule
